luhn_uart_sequencer: RTL

Byte-level controller between the UART receiver/transmitter pair and the card-number check. It collects ASCII digits from the receive stream and runs a streaming Luhn (mod-10) check. When it sees a line terminator it issues a three-byte verdict to the transmitter under a valid/ready handshake. It sits inside the top-level system, between the UART RX byte output and the UART TX byte input, and drives the halt/done status pins.

---
 rtl/luhn_pkg.sv | 33 +++
 rtl/luhn_acc.sv | 55 +++++
 rtl/luhn_uart_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/luhn_pkg.sv
// Shared types, ASCII constants and helpers
// for the Luhn UART sequencer.
package luhn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_SEND
    } luhn_state_t;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_V     = 8'h56;
    localparam logic [7:0] CH_I     = 8'h49;
    localparam logic [7:0] CH_E     = 8'h45;

    // Doubled digit folded back into 0..9.
    function automatic logic [3:0] luhn_dbl(
        input logic [3:0] d
    );
        logic [4:0] t;
        t = {d, 1'b0};
        if (t > 5'd9) begin
            t = t - 5'd9;
        end
        return t[3:0];
    endfunction

endpackage

// File: rtl/luhn_acc.sv
// Dual mod-10 accumulators: one doubles digits at
// even index, the other at odd index.
module luhn_acc
    import luhn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       dv,
    input  logic [3:0] digit,
    input  logic       parity,
    output logic [3:0] sum_e,
    output logic [3:0] sum_o
);

    logic [3:0] base_e;
    logic [3:0] base_o;
    logic [3:0] add_e;
    logic [3:0] add_o;

    function automatic logic [3:0] add10(
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

    // Operand selection: clear-and-load starts from zero.
    always_comb begin
        base_e = clr ? 4'd0 : sum_e;
        base_o = clr ? 4'd0 : sum_o;
        add_e  = parity ? digit : luhn_dbl(digit);
        add_o  = parity ? luhn_dbl(digit) : digit;
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_e <= 4'd0;
            sum_o <= 4'd0;
        end else if (dv) begin
            sum_e <= add10(base_e, add_e);
            sum_o <= add10(base_o, add_o);
        end else if (clr) begin
            sum_e <= 4'd0;
            sum_o <= 4'd0;
        end
    end

endmodule

// File: rtl/luhn_uart_sequencer.sv
// Collects ASCII digits, runs a streaming Luhn
// check and answers each line with a 3-byte verdict.
module luhn_uart_sequencer
    import luhn_pkg::*;
#(
    parameter int MIN_DIGITS = 13,
    parameter int MAX_DIGITS = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       halt
);

    localparam logic [4:0] MAX_W = 5'(MAX_DIGITS);
    localparam logic [4:0] MIN_W = 5'(MIN_DIGITS);

    luhn_state_t state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        err_q, err_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  verdict_q, verdict_d;
    logic        halt_q, halt_d;
    logic        done_q, done_d;

    logic        acc_clr;
    logic        acc_dv;
    logic        acc_par;
    logic [3:0]  sum_e;
    logic [3:0]  sum_o;
    logic [3:0]  sel_sum;
    logic [4:0]  cnt_inc;
    logic        is_digit;
    logic        is_space;
    logic        is_term;

    luhn_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .dv     (acc_dv),
        .digit  (rx_data[3:0]),
        .parity (acc_par),
        .sum_e  (sum_e),
        .sum_o  (sum_o)
    );

    // Byte classification and saturating count.
    always_comb begin
        is_digit = (rx_data >= CH_ZERO)
                && (rx_data <= CH_NINE);
        is_space = (rx_data == CH_SPACE);
        is_term  = (rx_data == CH_CR)
                || (rx_data == CH_LF);
        cnt_inc  = (count_q == 5'd31)
                 ? 5'd31 : count_q + 5'd1;
        sel_sum  = count_q[0] ? sum_o : sum_e;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        err_d     = err_q;
        idx_d     = idx_q;
        verdict_d = verdict_q;
        halt_d    = halt_q;
        done_d    = 1'b0;
        acc_clr   = 1'b0;
        acc_dv    = 1'b0;
        acc_par   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        acc_clr = 1'b1;
                        acc_dv  = 1'b1;
                        count_d = 5'd1;
                        err_d   = 1'b0;
                        state_d = S_COLLECT;
                    end else if (!is_space && !is_term) begin
                        err_d   = 1'b1;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        acc_dv  = 1'b1;
                        acc_par = count_q[0];
                        count_d = cnt_inc;
                        if (cnt_inc > MAX_W) begin
                            err_d = 1'b1;
                        end
                    end else if (is_term) begin
                        state_d = S_CHECK;
                    end else if (!is_space) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    halt_d = 1'b1;
                end
                if (err_q || (count_q < MIN_W)) begin
                    verdict_d = CH_E;
                end else if (sel_sum == 4'd0) begin
                    verdict_d = CH_V;
                end else begin
                    verdict_d = CH_I;
                end
                idx_d   = 2'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (rx_valid) begin
                    halt_d = 1'b1;
                end
                if (tx_ready) begin
                    if (idx_q == 2'd2) begin
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        count_d = 5'd0;
                        idx_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= 5'd0;
            err_q     <= 1'b0;
            idx_q     <= 2'd0;
            verdict_q <= 8'd0;
            halt_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            verdict_q <= verdict_d;
            halt_q    <= halt_d;
            done_q    <= done_d;
        end
    end

    // Transmit byte selection and status outputs.
    always_comb begin
        tx_valid = (state_q == S_SEND);
        tx_data  = 8'd0;
        if (state_q == S_SEND) begin
            unique case (idx_q)
                2'd0:    tx_data = verdict_q;
                2'd1:    tx_data = CH_CR;
                2'd2:    tx_data = CH_LF;
                default: tx_data = 8'd0;
            endcase
        end
        busy = (state_q != S_IDLE);
        done = done_q;
        halt = halt_q;
    end

endmodule
